// File: rtl/fifo_reader_pkg.sv
// rtl/fifo_reader_pkg.sv - shared reader/buffer state encodings and sizing helper
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        SEND = 2'b10
    } rd_state_t;

    function automatic int timer_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/fifo_reader_pop_timer.sv
// rtl/fifo_reader_pop_timer.sv - counts WAIT cycles without a valid word
module pop_timer
    import fifo_reader_pkg::*;
#(
    parameter int timeout = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int tw = timer_width(timeout);
    localparam logic [tw-1:0] last = tw'(timeout - 1);

    logic [tw-1:0] count;

    // Fires in the last empty cycle so the registered err lands timeout cycles after consume.
    always_comb expired = run && !clear && (count == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (run) begin
            count <= count + tw'(1);
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - pops words from an upstream buffer and hands them downstream
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int bit_width = 16,
    parameter int timeout   = 4,
    parameter int cnt_w     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 empty,
    input  logic [bit_width:0]   buf_data,
    output logic                 consume,
    output logic                 link_valid,
    output logic [bit_width-1:0] link_data,
    input  logic                 link_ack,
    output logic [cnt_w-1:0]     word_cnt,
    output logic                 err
);

    rd_state_t            state, state_nxt;
    logic                 armed;
    logic                 consume_nxt, valid_nxt, err_nxt;
    logic [bit_width-1:0] data_nxt;
    logic [cnt_w-1:0]     cnt_nxt;
    logic                 word_valid, in_wait, expired;

    assign word_valid = buf_data[bit_width];
    assign in_wait    = (state == WAIT);

    pop_timer #(.timeout(timeout)) u_pop_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait || word_valid),
        .run     (in_wait && !word_valid),
        .expired (expired)
    );

    always_comb begin
        state_nxt   = state;
        consume_nxt = 1'b0;
        valid_nxt   = link_valid;
        data_nxt    = link_data;
        err_nxt     = 1'b0;
        cnt_nxt     = word_cnt;
        case (state)
            IDLE: begin
                if (armed && en && !empty) begin
                    state_nxt   = WAIT;
                    consume_nxt = 1'b1;
                end
            end
            WAIT: begin
                // A valid word beats an expiring timer in the same cycle.
                if (word_valid) begin
                    data_nxt  = buf_data[bit_width-1:0];
                    valid_nxt = 1'b1;
                    state_nxt = SEND;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (link_ack) begin
                    cnt_nxt   = word_cnt + cnt_w'(1);
                    valid_nxt = 1'b0;
                    if (en && !empty) begin
                        state_nxt   = WAIT;
                        consume_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // armed holds off the first pop until the second edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            consume    <= 1'b0;
            link_valid <= 1'b0;
            link_data  <= '0;
            word_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            armed      <= 1'b1;
            consume    <= consume_nxt;
            link_valid <= valid_nxt;
            link_data  <= data_nxt;
            word_cnt   <= cnt_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - randomized self-checking bench for fifo_reader
module tb_fifo_reader;

    localparam int BW = 16;
    localparam int TO = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          empty = 1'b1;
    logic [BW:0]   buf_data = '0;
    logic          consume;
    logic          link_valid;
    logic [BW-1:0] link_data;
    logic          link_ack = 1'b0;
    logic [CW-1:0] word_cnt;
    logic          err;

    fifo_reader #(.bit_width(BW), .timeout(TO), .cnt_w(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .empty      (empty),
        .buf_data   (buf_data),
        .consume    (consume),
        .link_valid (link_valid),
        .link_data  (link_data),
        .link_ack   (link_ack),
        .word_cnt   (word_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] payload;
        int            delay;
    } ent_t;

    typedef struct {
        logic [BW-1:0] payload;
        int            vcyc;
    } exp_t;

    ent_t          bufq[$];
    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            accepted = 0;
    int            n_consume = 0;
    int            n_err = 0;
    int            exp_err_cycle = -1;
    int            wait_left = 0;
    int            hold_left = 0;
    int            ack_hold_cfg = 0;
    int            ack_pct = 100;
    int            en_pct = 100;
    int            gap_pct = 0;
    int            valid_cycles = 0;
    int            base_consume, base_err;
    bit            busy = 0;
    bit            pending = 0;
    bit            exp_consume_next = 0;
    logic [BW-1:0] pend_payload = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        en    = ($urandom_range(99) < en_pct);
        empty = (bufq.size() == 0) || ($urandom_range(99) < gap_pct);
        if (pending) begin
            if (wait_left == 0) begin
                buf_data = {1'b1, pend_payload};
                pending  = 0;
            end else begin
                buf_data = {1'b0, 16'($urandom)};
                wait_left--;
            end
        end else begin
            buf_data = 17'($urandom);
        end
        if (link_valid) begin
            if (hold_left > 0) begin
                link_ack = 1'b0;
                hold_left--;
            end else begin
                link_ack = ($urandom_range(99) < ack_pct);
            end
        end else begin
            link_ack = 1'($urandom_range(1));
        end
    endtask

    task automatic step();
        ent_t e;
        bit   exp_v;
        @(posedge clk);
        #1;
        cyc++;
        check("consume", 32'(consume), 32'(exp_consume_next));
        check("err", 32'(err), 32'(cyc == exp_err_cycle));
        check("word_cnt", 32'(word_cnt), 32'(accepted % 256));
        exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].vcyc);
        check("link_valid", 32'(link_valid), 32'(exp_v));
        if (link_valid && exp_q.size() > 0)
            check("link_data", 32'(link_data), 32'(exp_q[0].payload));
        if (consume) begin
            n_consume++;
            busy = 1;
            if (bufq.size() == 0) begin
                check("pop_nonempty", 0, 1);
            end else begin
                e = bufq.pop_front();
                if (e.delay < TO) exp_q.push_back('{e.payload, cyc + e.delay + 1});
                else exp_err_cycle = cyc + TO;
                pending      = 1;
                wait_left    = e.delay;
                pend_payload = e.payload;
            end
        end
        if (err) begin
            n_err++;
            busy = 0;
        end
        if (link_valid) valid_cycles++;
        drive_inputs();
        if (link_valid && link_ack) begin
            accepted++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            busy      = 0;
            hold_left = ack_hold_cfg;
        end
        exp_consume_next = !busy && en && !empty;
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while (!(bufq.size() == 0 && !busy && exp_q.size() == 0) && n < bound) begin
            step();
            n++;
        end
        check("drain", 32'(bufq.size() == 0 && !busy && exp_q.size() == 0), 1);
        repeat (TO + 3) step();
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; empty = 1'b1; link_ack = 1'b0; buf_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_consume", 32'(consume), 0);
        check("rst_link_valid", 32'(link_valid), 0);
        check("rst_link_data", 32'(link_data), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_err", 32'(err), 0);
        bufq.delete();
        exp_q.delete();
        busy = 0; pending = 0; exp_err_cycle = -1; accepted = 0; hold_left = ack_hold_cfg;
        rst = 1'b1;
        drive_inputs();
        exp_consume_next = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        do_reset();

        // single word, valid in the consume cycle
        base_consume = n_consume;
        bufq.push_back('{16'h00A5, 0});
        run_until_idle(50);
        check("single_consumes", 32'(n_consume - base_consume), 1);
        check("single_cnt", 32'(word_cnt), 1);

        // backpressure: ack low for 5 valid cycles
        base_consume = n_consume; valid_cycles = 0;
        ack_hold_cfg = 5; hold_left = 5;
        bufq.push_back('{16'h1234, 0});
        run_until_idle(50);
        check("bp_valid_cycles", 32'(valid_cycles), 6);
        check("bp_consumes", 32'(n_consume - base_consume), 1);
        check("bp_cnt", 32'(word_cnt), 2);
        ack_hold_cfg = 0; hold_left = 0;

        // back-to-back
        base_consume = n_consume;
        for (int i = 1; i <= 4; i++) bufq.push_back('{16'(i), 0});
        run_until_idle(50);
        check("b2b_consumes", 32'(n_consume - base_consume), 4);
        check("b2b_cnt", 32'(word_cnt), 6);

        // timeout, then the boundary pair: delay TO-1 delivers, delay TO times out
        base_err = n_err;
        bufq.push_back('{16'hBEEF, TO + 2});
        run_until_idle(50);
        check("to_errs", 32'(n_err - base_err), 1);
        check("to_cnt", 32'(word_cnt), 6);
        base_err = n_err;
        bufq.push_back('{16'h0111, TO - 1});
        bufq.push_back('{16'h0222, TO});
        run_until_idle(50);
        check("edge_errs", 32'(n_err - base_err), 1);
        check("edge_cnt", 32'(word_cnt), 7);

        // randomized traffic
        en_pct = 80; gap_pct = 20; ack_pct = 60;
        for (int i = 0; i < 60; i++)
            bufq.push_back('{16'($urandom), int'($urandom_range(TO + 1))});
        run_until_idle(5000);
        en_pct = 100; gap_pct = 0; ack_pct = 100;

        // async reset while a word is held in SEND
        ack_hold_cfg = 100; hold_left = 100;
        bufq.push_back('{16'h5A5A, 0});
        for (int i = 0; i < 20 && !link_valid; i++) step();
        check("reach_send", 32'(link_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_link_valid", 32'(link_valid), 0);
        check("async_word_cnt", 32'(word_cnt), 0);
        check("async_consume", 32'(consume), 0);
        ack_hold_cfg = 0;
        base_err = n_err;
        do_reset();
        repeat (10) step();
        check("post_rst_errs", 32'(n_err - base_err), 0);

        // counter wrap
        base_consume = n_consume;
        for (int i = 0; i < 256; i++) bufq.push_back('{16'(i), 0});
        run_until_idle(2000);
        check("wrap_consumes", 32'(n_consume - base_consume), 256);
        check("wrap_cnt", 32'(word_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter bit_width, default 16, payload width in bits.
REQ-002 Parameter timeout, default 4, maximum cycles WAIT holds for a valid word before abandoning.
REQ-003 Parameter cnt_w, default 8, width of word_cnt.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  drain enable; 0 blocks new pops but never aborts a word already in flight.
REQ-007 empty  input  1  buffer-empty flag from the upstream buffer.
REQ-008 buf_data  input  bit_width+1  buffer output; bit [bit_width] is the valid flag, [bit_width-1:0] is the payload.
REQ-009 consume  output  1  registered one-cycle pop request to the buffer.
REQ-010 link_valid  output  1  downstream word valid.
REQ-011 link_data  output  bit_width  downstream payload.
REQ-012 link_ack  input  1  downstream accepts link_data in the same cycle as link_valid=1.
REQ-013 word_cnt  output  cnt_w  count of words accepted downstream.
REQ-014 err  output  1  one-cycle pulse on a pop timeout.

Function
REQ-015 The FSM SHALL have exactly three states, encoded 2 bits: IDLE=00, WAIT=01, SEND=10.
REQ-016 IDLE SHALL go to WAIT and drive consume=1 on the next cycle when en=1 and empty=0; otherwise it stays in IDLE with consume=0.
REQ-017 consume SHALL be high for exactly one cycle per pop and never high outside the first cycle of WAIT.
REQ-018 WAIT SHALL sample buf_data every cycle, starting with the cycle consume=1.
- On buf_data[bit_width]=1: capture buf_data[bit_width-1:0] into link_data, set link_valid=1, go to SEND.
REQ-019 WAIT SHALL count the cycles without a valid word.
- When the count reaches timeout: pulse err=1 for one cycle, clear the count, return to IDLE, leave link_valid=0.
REQ-020 SEND SHALL hold link_valid=1 and keep link_data stable until a cycle with link_ack=1.
REQ-021 The cycle after an ack SHALL have link_valid=0 unless a back-to-back pop is issued.
REQ-022 On ack in SEND with en=1 and empty=0, the block SHALL drive consume=1 on the next cycle and enter WAIT (back-to-back pop). Otherwise it enters IDLE.
REQ-023 Latency SHALL be:
- empty falling (en=1, IDLE) to consume=1: 1 cycle.
- consume=1 to link_valid=1: 1 cycle when valid is returned in the consume cycle.
REQ-024 word_cnt SHALL increment by 1 on each cycle with link_valid=1 and link_ack=1, and SHALL wrap modulo 2^cnt_w.
REQ-025 link_ack while link_valid=0 SHALL be ignored.
REQ-026 empty rising while in WAIT or SEND SHALL NOT affect the current word.
REQ-027 en falling while in WAIT or SEND SHALL complete the current word, then enter IDLE.
REQ-028 A timeout counter reaching timeout in the same cycle as valid arrives SHALL be treated as valid: no err, go to SEND.

Reset
REQ-029 When rst=0, the block SHALL immediately and asynchronously set state=IDLE, consume=0, link_valid=0, link_data=0, word_cnt=0, err=0, and timeout count=0.
REQ-030 A reset asserted mid-WAIT or mid-SEND SHALL drop the in-flight word with no err pulse.
REQ-031 The first pop after rst returns to 1 SHALL occur no earlier than the second rising edge.

Structure
REQ-032 The state encodings IDLE, WAIT and SEND SHALL be defined as constants in the shared NoC tree package, which is also used by the buffer.
REQ-033 The timeout counter SHALL be a sub-module named pop_timer (inputs: clear, run; output: expired) with width ceil(log2(timeout+1)).
REQ-034 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-035 Single word: rst released, en=1, empty goes 0 and buf_data=1_0x00A5 in the consume cycle, link_ack=1 -> consume for 1 cycle, link_data=0x00A5 with link_valid for 1 cycle, word_cnt=1.
REQ-036 Backpressure: link_ack held 0 for 5 cycles, then 1 -> link_data=0x1234 stable for 6 cycles, only one consume pulse, word_cnt increments once.
REQ-037 Back-to-back: empty=0 throughout, ack always 1, words 0x0001..0x0004 -> 4 consume pulses, link_data 1,2,3,4 in order, word_cnt=4.
REQ-038 Timeout: timeout=4, buf_data[16] held 0 after consume -> err pulses once 4 cycles after consume, FSM in IDLE, link_valid never high.
REQ-039 Wrap: cnt_w=8, 256 words accepted -> word_cnt=0.
REQ-040 Reset mid-SEND: rst=0 while link_valid=1 -> link_valid=0 and word_cnt=0 immediately (before the next clk edge), state IDLE.
